// File: rtl/accel_pkg.sv
// Shared constants for the accelerometer sample buffer: register map,
// CTRL/STATUS/CLEAR bit positions, averager state encoding and a small
// absolute-difference helper used by the motion detector.
package accel_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_DATA_XY = 3'd2;
  localparam logic [2:0] ADDR_DATA_Z  = 3'd3;
  localparam logic [2:0] ADDR_THRESH  = 3'd4;
  localparam logic [2:0] ADDR_CLEAR   = 3'd5;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_AVG_EN_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_W          = 3;

  // STATUS bit positions
  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_OVERFLOW_BIT = 1;
  localparam int STATUS_MOTION_BIT   = 2;
  localparam int STATUS_COUNT_LSB    = 8;
  localparam int STATUS_COUNT_W      = 8;

  // CLEAR bit positions
  localparam int CLEAR_OVERFLOW_BIT = 0;
  localparam int CLEAR_MOTION_BIT   = 1;

  // Datapath widths
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 19;
  localparam int ENTRY_W  = 3 * SAMPLE_W;

  // Averager states
  typedef enum logic {
    AVG_ACCUM = 1'b0,
    AVG_PUSH  = 1'b1
  } avg_state_e;

  // |a - b| for two signed 16-bit samples; the 17-bit result cannot overflow.
  function automatic logic [16:0] abs_diff17(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    return d[16] ? (~d + 17'd1) : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view. Pointers wrap modulo
// DEPTH (power of two); a push while full is accepted only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Decide which of push/pop take effect and advance pointers and count.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/accel_sample_buffer.sv
// Accelerometer sample buffer: optional 2^AVG_LOG2 boxcar averaging of
// incoming x/y/z samples, a FIFO of {x,y,z} entries, motion detection
// between consecutive entries, and a small register interface with a
// level interrupt.
module accel_sample_buffer
  import accel_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          AVG_LOG2   = 2,
  parameter logic [15:0] THRESH_RST = 16'd2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int         CW      = $clog2(DEPTH) + 1;
  localparam logic [3:0] WIN_LEN = 4'(1 << AVG_LOG2);

  // ---------------------------------------------------------------- state
  avg_state_e               state_q, state_d;
  logic [3:0]               win_cnt_q, win_cnt_d;
  logic signed [ACC_W-1:0]  acc_x_q, acc_x_d;
  logic signed [ACC_W-1:0]  acc_y_q, acc_y_d;
  logic signed [ACC_W-1:0]  acc_z_q, acc_z_d;

  logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
  logic [15:0]              thresh_q, thresh_d;
  logic                     overflow_q, overflow_d;
  logic                     motion_q, motion_d;
  logic [31:0]              readdata_q, readdata_d;
  logic                     irq_q, irq_d;

  logic                     prev_valid_q, prev_valid_d;
  logic [15:0]              prev_x_q, prev_x_d;
  logic [15:0]              prev_y_q, prev_y_d;
  logic [15:0]              prev_z_q, prev_z_d;

  // ---------------------------------------------------------------- wiring
  logic                     enable, avg_en, irq_en;
  logic [3:0]               win_target;
  logic signed [ACC_W-1:0]  ext_x, ext_y, ext_z;
  logic signed [ACC_W-1:0]  avg_x, avg_y, avg_z;
  logic [15:0]              ent_x, ent_y, ent_z;
  logic                     push_req;
  logic                     fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]       fifo_wdata, fifo_rdata;
  logic [CW-1:0]            fifo_count;
  logic                     motion_hit, overflow_set;
  logic                     rd_hit, wr_hit;

  assign enable     = ctrl_q[CTRL_ENABLE_BIT];
  assign avg_en     = ctrl_q[CTRL_AVG_EN_BIT];
  assign irq_en     = ctrl_q[CTRL_IRQ_EN_BIT];
  assign win_target = avg_en ? WIN_LEN : 4'd1;

  assign ext_x = {{(ACC_W-SAMPLE_W){in_x[15]}}, in_x};
  assign ext_y = {{(ACC_W-SAMPLE_W){in_y[15]}}, in_y};
  assign ext_z = {{(ACC_W-SAMPLE_W){in_z[15]}}, in_z};

  // Arithmetic shift truncates toward minus infinity, matching sum>>>AVG_LOG2.
  assign avg_x = acc_x_q >>> AVG_LOG2;
  assign avg_y = acc_y_q >>> AVG_LOG2;
  assign avg_z = acc_z_q >>> AVG_LOG2;

  // In pass-through the window is one sample, so the accumulator holds it as-is.
  assign ent_x = avg_en ? avg_x[15:0] : acc_x_q[15:0];
  assign ent_y = avg_en ? avg_y[15:0] : acc_y_q[15:0];
  assign ent_z = avg_en ? avg_z[15:0] : acc_z_q[15:0];

  assign push_req   = (state_q == AVG_PUSH) && enable;
  assign fifo_wdata = {ent_x, ent_y, ent_z};

  assign rd_hit   = avs_read;
  assign wr_hit   = avs_write;
  assign fifo_pop = rd_hit && (avs_address == ADDR_DATA_Z) && !fifo_empty;

  // Upper write-data bits and shifted-out accumulator MSBs carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{avs_writedata[31:16], avg_x[ACC_W-1:16],
                         avg_y[ACC_W-1:16], avg_z[ACC_W-1:16]};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (fifo_pop),
    .wdata   (fifo_wdata),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Averager FSM: accumulate a window, then spend one cycle pushing it.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    acc_z_d   = acc_z_q;
    if (!enable) begin
      state_d   = AVG_ACCUM;
      win_cnt_d = '0;
      acc_x_d   = '0;
      acc_y_d   = '0;
      acc_z_d   = '0;
    end else begin
      case (state_q)
        AVG_ACCUM: begin
          if (in_valid) begin
            acc_x_d   = acc_x_q + ext_x;
            acc_y_d   = acc_y_q + ext_y;
            acc_z_d   = acc_z_q + ext_z;
            win_cnt_d = win_cnt_q + 4'd1;
            if (win_cnt_q + 4'd1 >= win_target) begin
              win_cnt_d = '0;
              state_d   = AVG_PUSH;
            end
          end
        end
        AVG_PUSH: begin
          // Entry leaves this cycle; a sample arriving now opens the next window.
          acc_x_d   = '0;
          acc_y_d   = '0;
          acc_z_d   = '0;
          win_cnt_d = '0;
          state_d   = AVG_ACCUM;
          if (in_valid) begin
            acc_x_d   = ext_x;
            acc_y_d   = ext_y;
            acc_z_d   = ext_z;
            win_cnt_d = 4'd1;
            if (win_target == 4'd1) begin
              win_cnt_d = '0;
              state_d   = AVG_PUSH;
            end
          end
        end
        default: state_d = AVG_ACCUM;
      endcase
    end
  end

  // Motion detector: compare each pushed entry with the previous one.
  always_comb begin
    prev_valid_d = prev_valid_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_z_d     = prev_z_q;
    motion_hit   = 1'b0;
    if (!enable) begin
      prev_valid_d = 1'b0;
    end else if (push_req) begin
      if (prev_valid_q) begin
        motion_hit = (abs_diff17(ent_x, prev_x_q) > {1'b0, thresh_q}) ||
                     (abs_diff17(ent_y, prev_y_q) > {1'b0, thresh_q}) ||
                     (abs_diff17(ent_z, prev_z_q) > {1'b0, thresh_q});
      end
      prev_valid_d = 1'b1;
      prev_x_d     = ent_x;
      prev_y_d     = ent_y;
      prev_z_d     = ent_z;
    end
  end

  // Register file: writes, sticky flags (set beats clear), read mux, irq.
  always_comb begin
    ctrl_d       = ctrl_q;
    thresh_d     = thresh_q;
    overflow_d   = overflow_q;
    motion_d     = motion_q;
    readdata_d   = readdata_q;
    overflow_set = push_req && fifo_full && !fifo_pop;

    if (wr_hit) begin
      case (avs_address)
        ADDR_CTRL:   ctrl_d   = avs_writedata[CTRL_W-1:0];
        ADDR_THRESH: thresh_d = avs_writedata[15:0];
        ADDR_CLEAR: begin
          if (avs_writedata[CLEAR_OVERFLOW_BIT]) overflow_d = 1'b0;
          if (avs_writedata[CLEAR_MOTION_BIT])   motion_d   = 1'b0;
        end
        default: ;
      endcase
    end
    if (overflow_set) overflow_d = 1'b1;
    if (motion_hit)   motion_d   = 1'b1;

    if (rd_hit) begin
      readdata_d = '0;
      case (avs_address)
        ADDR_STATUS: begin
          readdata_d[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
          readdata_d[STATUS_MOTION_BIT]   = motion_q;
          readdata_d[STATUS_OVERFLOW_BIT] = overflow_q;
          readdata_d[STATUS_EMPTY_BIT]    = fifo_empty;
        end
        ADDR_CTRL:    readdata_d[CTRL_W-1:0] = ctrl_q;
        ADDR_DATA_XY: if (!fifo_empty) readdata_d = fifo_rdata[ENTRY_W-1:SAMPLE_W];
        ADDR_DATA_Z:  if (!fifo_empty) readdata_d[15:0] = fifo_rdata[SAMPLE_W-1:0];
        ADDR_THRESH:  readdata_d[15:0] = thresh_q;
        default:      readdata_d = '0;
      endcase
    end

    irq_d = irq_en && (motion_q || overflow_q || (fifo_count >= CW'(DEPTH / 2)));
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= AVG_ACCUM;
      win_cnt_q    <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      acc_z_q      <= '0;
      ctrl_q       <= '0;
      thresh_q     <= THRESH_RST;
      overflow_q   <= 1'b0;
      motion_q     <= 1'b0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_z_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      acc_z_q      <= acc_z_d;
      ctrl_q       <= ctrl_d;
      thresh_q     <= thresh_d;
      overflow_q   <= overflow_d;
      motion_q     <= motion_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
      prev_valid_q <= prev_valid_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_z_q     <= prev_z_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_accel_sample_buffer.sv
// Directed test of accel_sample_buffer with hand-computed expected values.
module tb_accel_sample_buffer;
  import accel_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_x, in_y, in_z;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  accel_sample_buffer #(
    .DEPTH      (16),
    .AVG_LOG2   (2),
    .THRESH_RST (16'd2000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_z          (in_z),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %-16s got 0x%08h required 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %-16s 0x%08h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // One in_valid strobe, then one idle cycle so any resulting push lands.
  task automatic sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    reset_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    read_check("rst_status", ADDR_STATUS, 32'h0000_0001);
    read_check("rst_ctrl", ADDR_CTRL, 32'h0);
    read_check("rst_thresh", ADDR_THRESH, 32'h0000_07D0);

    // Disabled: samples ignored
    sample(16'd5, 16'd5, 16'd5);
    read_check("dis_status", ADDR_STATUS, 32'h0000_0001);

    // Pass-through
    bus_write(ADDR_CTRL, 32'h1);
    sample(16'd1, 16'hFFFE, 16'd3);
    read_check("pt_status", ADDR_STATUS, 32'h0000_0100);
    read_check("pt_xy", ADDR_DATA_XY, 32'h0001_FFFE);
    read_check("pt_z", ADDR_DATA_Z, 32'h0000_0003);
    read_check("pt_empty", ADDR_STATUS, 32'h0000_0001);
    read_check("empty_z", ADDR_DATA_Z, 32'h0);
    read_check("empty_xy", ADDR_DATA_XY, 32'h0);
    read_check("empty_status", ADDR_STATUS, 32'h0000_0001);

    // Averaging: 10,11,12,-1 -> 8 ; -1,-1,-1,-2 -> -2
    bus_write(ADDR_CTRL, 32'h3);
    sample(16'd10, 16'd0, 16'd0);
    sample(16'd11, 16'd0, 16'd0);
    read_check("avg_partial", ADDR_STATUS, 32'h0000_0001);
    sample(16'd12, 16'd0, 16'd0);
    sample(16'hFFFF, 16'd0, 16'd0);
    read_check("avg1_status", ADDR_STATUS, 32'h0000_0100);
    read_check("avg1_xy", ADDR_DATA_XY, 32'h0008_0000);
    read_check("avg1_z", ADDR_DATA_Z, 32'h0);
    sample(16'hFFFF, 16'd0, 16'd0);
    sample(16'hFFFF, 16'd0, 16'd0);
    sample(16'hFFFF, 16'd0, 16'd0);
    sample(16'hFFFE, 16'd0, 16'd0);
    read_check("avg2_xy", ADDR_DATA_XY, 32'hFFFE_0000);
    read_check("avg2_z", ADDR_DATA_Z, 32'h0);
    read_check("avg2_status", ADDR_STATUS, 32'h0000_0001);

    // Reset after 2 of 4 window samples discards them
    sample(16'd7, 16'd7, 16'd7);
    sample(16'd7, 16'd7, 16'd7);
    do_reset();
    read_check("mid_rst_status", ADDR_STATUS, 32'h0000_0001);
    read_check("mid_rst_ctrl", ADDR_CTRL, 32'h0);
    bus_write(ADDR_CTRL, 32'h3);
    sample(16'd4, 16'd100, 16'hFFF8);
    sample(16'd4, 16'd0, 16'hFFF8);
    sample(16'd4, 16'd0, 16'hFFF8);
    sample(16'd4, 16'd0, 16'hFFF8);
    read_check("win_status", ADDR_STATUS, 32'h0000_0100);
    read_check("win_xy", ADDR_DATA_XY, 32'h0004_0019);
    read_check("win_z", ADDR_DATA_Z, 32'h0000_FFF8);

    // Motion threshold: difference of exactly THRESH does not trigger
    bus_write(ADDR_THRESH, 32'd100);
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_CTRL, 32'h1);
    sample(16'd0, 16'd0, 16'd0);
    sample(16'd0, 16'd0, 16'd100);
    sample(16'd0, 16'd0, 16'd0);
    read_check("mot_none", ADDR_STATUS, 32'h0000_0300);
    sample(16'd0, 16'd0, 16'd101);
    read_check("mot_set", ADDR_STATUS, 32'h0000_0404);
    bus_write(ADDR_CLEAR, 32'h2);
    read_check("mot_clear", ADDR_STATUS, 32'h0000_0400);
    read_check("drain_z0", ADDR_DATA_Z, 32'h0);
    read_check("drain_z1", ADDR_DATA_Z, 32'h0000_0064);
    read_check("drain_z2", ADDR_DATA_Z, 32'h0);
    read_check("drain_z3", ADDR_DATA_Z, 32'h0000_0065);

    // Overflow: 17 pushes into 16 entries
    bus_write(ADDR_CTRL, 32'h5);
    @(negedge clk);
    check("irq_idle", {31'b0, irq}, 32'h0);
    for (int i = 1; i <= 17; i++) begin
      sample(16'(i), 16'd0, 16'(i));
    end
    read_check("ovf_status", ADDR_STATUS, 32'h0000_1002);
    check("ovf_irq", {31'b0, irq}, 32'h1);
    read_check("ovf_head_xy", ADDR_DATA_XY, 32'h0001_0000);
    read_check("ovf_head_z", ADDR_DATA_Z, 32'h0000_0001);
    read_check("ovf_after_pop", ADDR_STATUS, 32'h0000_0F02);

    // Simultaneous push and pop while full
    bus_write(ADDR_CLEAR, 32'h1);
    read_check("ovf_cleared", ADDR_STATUS, 32'h0000_0F00);
    sample(16'd18, 16'd0, 16'd18);
    read_check("full_again", ADDR_STATUS, 32'h0000_1000);
    @(negedge clk);
    in_valid = 1'b1; in_x = 16'd19; in_y = 16'd0; in_z = 16'd19;
    @(negedge clk);
    in_valid = 1'b0; avs_address = ADDR_DATA_Z; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
    check("pp_pop_z", d, 32'h0000_0002);
    read_check("pp_status", ADDR_STATUS, 32'h0000_1000);
    check("pp_irq", {31'b0, irq}, 32'h1);
    read_check("pp_head_xy", ADDR_DATA_XY, 32'h0003_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/accel_sample_buffer.md
ACCEL_SAMPLE_BUFFER -- requirements
Module: accel_sample_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving FIFO entries (power of 2, 4..64).
REQ-002 SHALL have parameter AVG_LOG2, default 2, giving averaging window 2^AVG_LOG2 samples (0..3).
REQ-003 SHALL have parameter THRESH_RST, default 16'd2000, giving reset value of the motion threshold.
REQ-004 SHALL have the following ports; clock and reset as already decided (reset reset_n, asynchronous, active-low; clock clk):
 clk  in  1  system clock
 reset_n  in  1  asynchronous active-low reset
 in_valid  in  1  one-cycle strobe, new accelerometer sample
 in_x, in_y, in_z  in  16 each  signed two's-complement axis samples, valid with in_valid
 avs_address  in  3  register word address
 avs_read  in  1  read strobe
 avs_write  in  1  write strobe
 avs_writedata  in  32  write data
 avs_readdata  out  32  read data
 irq  out  1  level interrupt to HPS

Function
REQ-005 SHALL ignore in_valid while CTRL.enable=0; the accumulator SHALL be held cleared.
REQ-006 With CTRL.avg_en=1, SHALL sum 2^AVG_LOG2 consecutive samples per axis in 19-bit signed accumulators, then push sum>>>AVG_LOG2 (arithmetic, truncated) as one entry.
REQ-007 With CTRL.avg_en=0, SHALL push every accepted sample unmodified.
REQ-008 Averager FSM states: ACCUM (count samples), PUSH (one cycle, write entry, clear accumulators, return to ACCUM); an in_valid during PUSH SHALL be accumulated as the first sample of the next window.
REQ-009 Push SHALL occur one cycle after the in_valid completing the window (latency 1 clk in pass-through mode).
REQ-010 FIFO entry SHALL be 48 bits {x,y,z}; pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-011 Push when full SHALL drop the entry, leave the FIFO unchanged, and set sticky STATUS.overflow.
REQ-012 Simultaneous push and pop SHALL both take effect; count unchanged (when full, the pop frees space, so the push is accepted).
REQ-013 Register map (word addresses): 0 STATUS RO {motion[2], overflow[1], empty[0], count[15:8]}; 1 CTRL RW {irq_en[2], avg_en[1], enable[0]}; 2 DATA_XY RO {x[31:16], y[15:0]} of head; 3 DATA_Z RO {16'b0, z}, read pops; 4 THRESH RW [15:0]; 5 CLEAR WO, bit0 clears overflow, bit1 clears motion; others read 0.
REQ-014 avs_readdata SHALL be registered, valid the cycle after avs_read, fixed 1-cycle latency, no waitrequest.
REQ-015 Read of DATA_Z when empty SHALL return 0 and not change pointers; DATA_XY when empty SHALL return 0.
REQ-016 Motion: on each push, SHALL compute |new - previous pushed| per axis (17-bit); if any exceeds THRESH, set sticky motion; first push after reset/enable SHALL only load previous.
REQ-017 irq SHALL equal irq_en & (motion | overflow | count >= DEPTH/2), registered.
REQ-018 Sticky-set and CLEAR write in the same cycle: set SHALL win.
REQ-019 Clearing CTRL.enable SHALL flush the accumulator and window counter but preserve FIFO contents.

Reset
REQ-020 On reset_n low, SHALL asynchronously clear pointers, count, accumulators, window counter, sticky flags, CTRL (=0), previous-sample registers, avs_readdata=0, irq=0; THRESH=THRESH_RST; FSM to ACCUM.
REQ-021 Reset mid-window SHALL discard partial sums; no entry is pushed.

Structure
REQ-022 Register address constants and CTRL/STATUS bit positions SHALL live in shared package accel_pkg.
REQ-023 FIFO storage/pointers SHALL be a sub-module sync_fifo (parameterised width/depth, full/empty/count).

Verification
REQ-024 Pass-through: enable=1, avg_en=0, push x=1,y=-2,z=3 -> STATUS.count=1; DATA_XY=0x0001FFFE, DATA_Z=0x00000003, then empty=1.
REQ-025 Averaging AVG_LOG2=2: x samples 10,11,12,-1 -> one entry x=8 (32>>>2); samples -1,-1,-1,-2 -> x=-2.
REQ-026 Overflow: 17 pushes, DEPTH=16 -> count=16, overflow=1, irq=1 (irq_en=1); first pop returns first sample.
REQ-027 Simultaneous push+pop with FIFO full -> count stays 16, no overflow set.
REQ-028 Motion: THRESH=100, consecutive entries z=0 then z=101 -> motion=1; z=0 then z=100 -> motion=0; CLEAR bit1 -> motion=0.
REQ-029 Reset asserted after 2 of 4 window samples -> no entry; next 4 samples produce one correct entry.
